// File: rtl/sync_fifo_tmr.sv
// sync_fifo_tmr: parametrised synchronous FIFO for the UART byte buffers.
// The read/write pointers and the sticky flags can optionally be held in
// three copies that are majority-voted and rewritten on every clock edge.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   n_clr_i    synchronous clear, active-low (wins over read and write)
//   n_we_i     write strobe, active-low
//   data_i     write data
//   n_re_i     read strobe, active-low
//   thresh_i   level threshold
//   data_o     read data (registered, or head word in FWFT mode)
//   p_valid_o  data_o holds a valid word
//   level_o    number of stored words, 0..DEPTH
//   p_full_o   level_o == DEPTH
//   p_empty_o  level_o == 0
//   p_thresh_o level_o >= thresh_i
//   p_over_o   sticky overflow
//   p_under_o  sticky underflow
module sync_fifo_tmr #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int FWFT       = 0,
  parameter int OVERWRITE  = 1,
  parameter int TMR        = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  n_clr_i,
  input  logic                  n_we_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  n_re_i,
  input  logic [ADDR_WIDTH:0]   thresh_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  p_valid_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  p_full_o,
  output logic                  p_empty_o,
  output logic                  p_thresh_o,
  output logic                  p_over_o,
  output logic                  p_under_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NC    = (TMR != 0) ? 3 : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] wrPtr_q [NC];
  logic [ADDR_WIDTH:0] rdPtr_q [NC];
  logic [NC-1:0]       over_q;
  logic [NC-1:0]       under_q;

  logic [ADDR_WIDTH:0] wrPtr, rdPtr, wrPtr_d, rdPtr_d, level;
  logic                over, under, over_d, under_d;
  logic                full, empty, wrEn, rdEn, dropOld;

  // Voted view of the protected registers; a single upset copy is outvoted.
  if (TMR != 0) begin : gVote
    assign wrPtr = (wrPtr_q[0] & wrPtr_q[1]) | (wrPtr_q[0] & wrPtr_q[2]) | (wrPtr_q[1] & wrPtr_q[2]);
    assign rdPtr = (rdPtr_q[0] & rdPtr_q[1]) | (rdPtr_q[0] & rdPtr_q[2]) | (rdPtr_q[1] & rdPtr_q[2]);
    assign over  = (over_q[0] & over_q[1]) | (over_q[0] & over_q[2]) | (over_q[1] & over_q[2]);
    assign under = (under_q[0] & under_q[1]) | (under_q[0] & under_q[2]) | (under_q[1] & under_q[2]);
  end else begin : gSingle
    assign wrPtr = wrPtr_q[0];
    assign rdPtr = rdPtr_q[0];
    assign over  = over_q[0];
    assign under = under_q[0];
  end

  // Pointers carry one extra bit so that full and empty are distinguishable.
  assign level = wrPtr - rdPtr;
  assign full  = (level == DEPTH_LVL);
  assign empty = (level == '0);

  // Request acceptance and next pointer/flag state.  dropOld marks an
  // overwrite of the oldest word, which must also advance the read pointer.
  always_comb begin
    rdEn    = !n_re_i && !empty;
    wrEn    = !n_we_i && (!full || rdEn || (OVERWRITE != 0));
    dropOld = wrEn && full && !rdEn;
    wrPtr_d = wrPtr;
    rdPtr_d = rdPtr;
    over_d  = over;
    under_d = under;
    if (!n_clr_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      over_d  = 1'b0;
      under_d = 1'b0;
    end else begin
      if (wrEn) wrPtr_d = wrPtr + 1'b1;
      if (rdEn || dropOld) rdPtr_d = rdPtr + 1'b1;
      if (!n_we_i && full && !rdEn) over_d = 1'b1;
      if (!n_re_i && empty) under_d = 1'b1;
    end
  end

  // All copies are rewritten every cycle from the voted next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NC; i++) begin
        wrPtr_q[i] <= '0;
        rdPtr_q[i] <= '0;
        over_q[i]  <= 1'b0;
        under_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NC; i++) begin
        wrPtr_q[i] <= wrPtr_d;
        rdPtr_q[i] <= rdPtr_d;
        over_q[i]  <= over_d;
        under_q[i] <= under_d;
      end
    end
  end

  // Storage is neither reset nor cleared; a clear suppresses the write.
  always_ff @(posedge clk) begin
    if (wrEn && n_clr_i) mem[wrPtr[ADDR_WIDTH-1:0]] <= data_i;
  end

  if (FWFT != 0) begin : gFwft
    // Head word is shown directly; forced to zero while empty so that reset
    // and clear present a defined value.
    assign data_o    = empty ? '0 : mem[rdPtr[ADDR_WIDTH-1:0]];
    assign p_valid_o = !empty;
  end else begin : gStd
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;

    always_comb begin
      data_d  = data_q;
      valid_d = 1'b0;
      if (!n_clr_i) begin
        data_d = '0;
      end else if (rdEn) begin
        data_d  = mem[rdPtr[ADDR_WIDTH-1:0]];
        valid_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end

    assign data_o    = data_q;
    assign p_valid_o = valid_q;
  end

  assign level_o    = level;
  assign p_full_o   = full;
  assign p_empty_o  = empty;
  assign p_thresh_o = (level >= thresh_i);
  assign p_over_o   = over;
  assign p_under_o  = under;

endmodule

// File: tb/tb_sync_fifo_tmr.sv
// tb_sync_fifo_tmr: drives two FIFO configurations with identical stimulus
// and compares them with a word-count/head-index reference model.
//   dutA: ADDR_WIDTH=3, standard read, overwrite-oldest, TMR on
//   dutB: ADDR_WIDTH=3, FWFT read, drop-new, TMR off
module tb_sync_fifo_tmr;

  logic       clk = 1'b0;
  logic       rst;
  logic       nClr, nWe, nRe;
  logic [7:0] din;
  logic [3:0] thresh;

  logic [7:0] dataA, dataB;
  logic [3:0] levelA, levelB;
  logic       validA, fullA, emptyA, threshA, overA, underA;
  logic       validB, fullB, emptyB, threshB, overB, underB;

  int nChecks = 0;
  int nErrors = 0;

  // Reference model: per DUT a circular store with head index and count.
  int mMem [2][8];
  int mHead [2];
  int mCount [2];
  int mWr [2];
  int mData [2];
  bit mOver [2];
  bit mUnder [2];
  bit mValid [2];

  always #5 clk = ~clk;

  sync_fifo_tmr #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(0), .OVERWRITE(1), .TMR(1)) dutA (
    .clk(clk), .rst(rst), .n_clr_i(nClr), .n_we_i(nWe), .data_i(din), .n_re_i(nRe),
    .thresh_i(thresh), .data_o(dataA), .p_valid_o(validA), .level_o(levelA),
    .p_full_o(fullA), .p_empty_o(emptyA), .p_thresh_o(threshA),
    .p_over_o(overA), .p_under_o(underA));

  sync_fifo_tmr #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(1), .OVERWRITE(0), .TMR(0)) dutB (
    .clk(clk), .rst(rst), .n_clr_i(nClr), .n_we_i(nWe), .data_i(din), .n_re_i(nRe),
    .thresh_i(thresh), .data_o(dataB), .p_valid_o(validB), .level_o(levelB),
    .p_full_o(fullB), .p_empty_o(emptyB), .p_thresh_o(threshB),
    .p_over_o(overB), .p_under_o(underB));

  task automatic checkOutput(input string tag, input int obs, input int exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mHead[d] = 0; mCount[d] = 0; mWr[d] = 0; mData[d] = 0;
      mOver[d] = 1'b0; mUnder[d] = 1'b0; mValid[d] = 1'b0;
    end
  endtask

  // One clock edge of FIFO behaviour.  Reads are applied before writes so a
  // write into a full FIFO with a read lands in the slot just freed.
  task automatic modelStep();
    for (int d = 0; d < 2; d++) begin
      bit re, we;
      if (!nClr) begin
        mHead[d] = 0; mCount[d] = 0; mWr[d] = 0; mData[d] = 0;
        mOver[d] = 1'b0; mUnder[d] = 1'b0; mValid[d] = 1'b0;
      end else begin
        re = !nRe && (mCount[d] > 0);
        we = !nWe && ((mCount[d] < 8) || re || (d == 0));
        if (!nRe && mCount[d] == 0) mUnder[d] = 1'b1;
        if (!nWe && mCount[d] == 8 && !re) mOver[d] = 1'b1;
        mValid[d] = re;
        if (re) begin
          mData[d]  = mMem[d][mHead[d]];
          mHead[d]  = (mHead[d] + 1) % 8;
          mCount[d] = mCount[d] - 1;
        end
        if (we) begin
          mWr[d] = (mWr[d] + 1) % 16;
          if (mCount[d] == 8) begin
            mMem[d][mHead[d]] = int'(din);
            mHead[d] = (mHead[d] + 1) % 8;
          end else begin
            mMem[d][(mHead[d] + mCount[d]) % 8] = int'(din);
            mCount[d] = mCount[d] + 1;
          end
        end
      end
    end
  endtask

  task automatic checkDut(input string p, input int d, input int lvl, input int full,
                          input int empty, input int over, input int under,
                          input int valid, input int data, input int thr);
    int expData, expValid;
    if (d == 1) begin
      expValid = (mCount[d] > 0) ? 1 : 0;
      expData  = (mCount[d] > 0) ? mMem[d][mHead[d]] : 0;
    end else begin
      expValid = int'(mValid[d]);
      expData  = mData[d];
    end
    checkOutput({p, ".level"}, lvl, mCount[d]);
    checkOutput({p, ".full"}, full, (mCount[d] == 8) ? 1 : 0);
    checkOutput({p, ".empty"}, empty, (mCount[d] == 0) ? 1 : 0);
    checkOutput({p, ".over"}, over, int'(mOver[d]));
    checkOutput({p, ".under"}, under, int'(mUnder[d]));
    checkOutput({p, ".valid"}, valid, expValid);
    checkOutput({p, ".data"}, data, expData);
    checkOutput({p, ".thresh"}, thr, (mCount[d] >= int'(thresh)) ? 1 : 0);
  endtask

  task automatic checkAll();
    checkDut("A", 0, int'(levelA), int'(fullA), int'(emptyA), int'(overA), int'(underA),
             int'(validA), int'(dataA), int'(threshA));
    checkDut("B", 1, int'(levelB), int'(fullB), int'(emptyB), int'(overB), int'(underB),
             int'(validB), int'(dataB), int'(threshB));
  endtask

  // Inputs change just after a falling edge; outputs are checked on the next one.
  task automatic applyStimulus(input logic c, input logic w, input logic r, input logic [7:0] d);
    nClr = c; nWe = w; nRe = r; din = d;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    int wp, rp;
    rst = 1'b0; nClr = 1'b1; nWe = 1'b1; nRe = 1'b1; din = 8'h00; thresh = 4'd0;
    modelReset();
    repeat (2) @(negedge clk);
    checkAll();
    thresh = 4'd6;
    #1 checkAll();
    @(negedge clk);
    rst = 1'b1;

    // Fill and drain.
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b0, 1'b1, 8'(i));
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);

    // Write into a full FIFO: overwrite on A, drop on B.
    for (int i = 1; i <= 9; i++) applyStimulus(1'b1, 1'b0, 1'b1, 8'(i));
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);

    // Clear together with a write: the write must be ignored.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hEE);

    // FWFT first word, threshold crossing, then full read+write.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hA5);
    for (int i = 1; i <= 7; i++) applyStimulus(1'b1, 1'b0, 1'b1, 8'(8'h30 + i));
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h51);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h52);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);

    // Empty read+write: write accepted, underflow flagged, data held.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h77);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);

    // Asynchronous reset in the middle of a cycle.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h11);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h12);
    #2 rst = 1'b0;
    #1 modelReset();
    checkAll();
    @(negedge clk);
    checkAll();
    rst = 1'b1;

    // Upset one copy of the write pointer; the vote must hide it and the
    // next edge must repair it.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 8'(8'hC0 + i));
    dutA.wrPtr_q[1] = dutA.wrPtr_q[1] ^ 4'b0101;
    #1 checkAll();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
    checkOutput("A.scrub_r2", int'(dutA.wrPtr_q[1]), mWr[0]);

    // Random phases alternating between write-heavy and read-heavy traffic.
    for (int ph = 0; ph < 8; ph++) begin
      wp = (ph % 2 == 0) ? 75 : 25;
      rp = 100 - wp;
      thresh = 4'($urandom_range(0, 8));
      for (int i = 0; i < 50; i++) begin
        applyStimulus(($urandom_range(0, 59) != 0),
                      ($urandom_range(0, 99) >= wp),
                      ($urandom_range(0, 99) >= rp),
                      8'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
